lzd_2bit: RTL and testbench

- Registered 2-bit leading-zero detector (LZD) leaf cell.
- Reports the leading-zero count of a 2-bit slice (0 or 1) and a valid flag that is set when the slice is non-zero.
- Used as the building block of wider LZD trees (4-bit, 8-bit, ...) in the AWGN generator's normalisation path. Parent nodes combine two leaf results as {~valid_hi, valid_hi ? cnt_hi : cnt_lo}.

---
 rtl/lzd_pkg.sv | 39 +++
 rtl/lzd_2bit.sv | 80 ++++++++
 tb/tb_lzd_2bit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero detector tree.
// The leaf function lzd2_f is used by the 2-bit leaf cell and by tree nodes.
// lzd_merge4_f combines two leaf results into a 4-bit node result.
// lzd_res_t is the result record that parent nodes hand upward.
package lzd_pkg;

    localparam int unsigned LZD_LEAF_W     = 32'd2;
    localparam int unsigned LZD_NODE_CNT_W = 32'd2;

    typedef struct packed {
        logic                      valid;
        logic [LZD_NODE_CNT_W-1:0] cnt;
    } lzd_res_t;

    // Leaf evaluation: returns {valid, cnt}. An all-zero slice gives cnt=0,
    // so parents can rely on a clean zero count when nothing is set.
    function automatic logic [1:0] lzd2_f(input logic [LZD_LEAF_W-1:0] din);
        logic v_s;
        logic c_s;
        v_s = din[1] | din[0];
        c_s = ~din[1] & din[0];
        return {v_s, c_s};
    endfunction

    // Parent node: {~valid_hi, valid_hi ? cnt_hi : cnt_lo}. When neither
    // half is valid the count is forced to zero rather than reporting 2.
    function automatic lzd_res_t lzd_merge4_f(input logic v_hi, input logic c_hi,
                                              input logic v_lo, input logic c_lo);
        lzd_res_t res;
        res.valid = v_hi | v_lo;
        if (res.valid) begin
            res.cnt = {~v_hi, (v_hi ? c_hi : c_lo)};
        end else begin
            res.cnt = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/lzd_2bit.sv
// 2-bit leading-zero detector leaf cell.
// Ports:
//   clk   - system clock, rising edge (unused when REG_OUT=0)
//   rst_n - asynchronous active-low reset (unused when REG_OUT=0)
//   en    - sample enable; din is captured on a rising edge when high
//   din   - 2-bit slice, din[1] is the MSB
//   cnt   - leading-zero count (0 or 1), 0 for an all-zero slice
//   valid - slice is non-zero
//   vld_o - strobe: cnt/valid were updated on the last clock edge
// REG_OUT=1 registers the outputs (1-cycle latency); REG_OUT=0 is purely
// combinational with vld_o following en.
module lzd_2bit
    import lzd_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [LZD_LEAF_W-1:0] din,
    output logic                  cnt,
    output logic                  valid,
    output logic                  vld_o
);

    logic [1:0] res_s;

    assign res_s = lzd2_f(din);

    generate
        if (REG_OUT) begin : g_reg
            logic cnt_q;
            logic cnt_d;
            logic valid_q;
            logic valid_d;
            logic vld_q;
            logic vld_d;

            // Next-state: load a fresh result on en, otherwise hold it.
            always_comb begin
                cnt_d   = cnt_q;
                valid_d = valid_q;
                vld_d   = 1'b0;
                if (en) begin
                    cnt_d   = res_s[0];
                    valid_d = res_s[1];
                    vld_d   = 1'b1;
                end else begin
                    vld_d   = 1'b0;
                end
            end

            // Output registers, cleared asynchronously by rst_n.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q   <= 1'b0;
                    valid_q <= 1'b0;
                    vld_q   <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    valid_q <= valid_d;
                    vld_q   <= vld_d;
                end
            end

            assign cnt   = cnt_q;
            assign valid = valid_q;
            assign vld_o = vld_q;
        end else begin : g_comb
            // clk and rst_n have no function in the stateless variant.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst_n;

            assign cnt   = res_s[0];
            assign valid = res_s[1];
            assign vld_o = en;
        end
    endgenerate

endmodule

// File: tb/tb_lzd_2bit.sv
// Self-checking bench for lzd_2bit: registered leaf, combinational leaf and a
// 4-bit node built from two combinational leaves.
module tb_lzd_2bit;
    import lzd_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] din;
    logic       cnt;
    logic       valid;
    logic       vld_o;

    logic       c_en;
    logic [1:0] c_din;
    logic       c_cnt;
    logic       c_valid;
    logic       c_vld;

    logic [3:0] din4;
    logic       hi_cnt, hi_valid, hi_vld;
    logic       lo_cnt, lo_valid, lo_vld;
    lzd_res_t   node_s;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered state maintained by the reference model.
    logic exp_cnt, exp_valid, exp_vld;

    lzd_2bit #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .cnt(cnt), .valid(valid), .vld_o(vld_o)
    );

    lzd_2bit #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .en(c_en), .din(c_din),
        .cnt(c_cnt), .valid(c_valid), .vld_o(c_vld)
    );

    lzd_2bit #(.REG_OUT(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .din(din4[3:2]),
        .cnt(hi_cnt), .valid(hi_valid), .vld_o(hi_vld)
    );

    lzd_2bit #(.REG_OUT(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .din(din4[1:0]),
        .cnt(lo_cnt), .valid(lo_valid), .vld_o(lo_vld)
    );

    assign node_s = lzd_merge4_f(hi_valid, hi_cnt, lo_valid, lo_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal-input monitor: unknown din while enabled.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && en === 1'b1 && $isunknown(din)) begin
            $error("illegal unknown din while en=1");
        end
    end

    // Reference: count zeros from the MSB down; an all-zero word reports 0.
    function automatic int ref_lz(input logic [3:0] v, input int w);
        int n;
        n = 0;
        if (v == 4'd0) return 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // One registered-mode clock: drive at negedge, model at posedge, check next negedge.
    task automatic cycle(input logic e, input logic [1:0] d, input string tag);
        en  = e;
        din = d;
        @(posedge clk);
        if (rst_n) begin
            if (e) begin
                exp_cnt   = (ref_lz({2'b00, d}, 2) == 1);
                exp_valid = (d != 2'b00);
            end
            exp_vld = e;
        end
        @(negedge clk);
        n_cmp++;
        if ({cnt, valid, vld_o} !== {exp_cnt, exp_valid, exp_vld}) begin
            n_err++;
            $display("FAIL %s din=%b en=%b: got cnt/valid/vld=%b%b%b expected %b%b%b",
                     tag, d, e, cnt, valid, vld_o, exp_cnt, exp_valid, exp_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        din   = 2'b01;
        exp_cnt = 1'b0; exp_valid = 1'b0; exp_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cnt, valid, vld_o} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got %b%b%b expected 000", i, cnt, valid, vld_o);
            end
        end
        rst_n = 1'b1;
        cycle(1'b1, 2'b01, "reset_release");
        n_cmp++;
        if ({cnt, valid, vld_o} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_first_capture: got %b%b%b expected 111", cnt, valid, vld_o);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] d;
            d = 2'(i);
            cycle(1'b1, d, "sweep");
        end
    endtask

    task automatic test_enable_hold();
        cycle(1'b1, 2'b01, "hold_load");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b10, "hold");
            n_cmp++;
            if ({cnt, valid, vld_o} !== 3'b110) begin
                n_err++;
                $display("FAIL hold_const: got %b%b%b expected 110", cnt, valid, vld_o);
            end
        end
        cycle(1'b1, 2'b10, "hold_reenable");
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 2'b01, "arst_load");
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 1'b0; exp_valid = 1'b0; exp_vld = 1'b0;
        n_cmp++;
        if ({cnt, valid, vld_o} !== 3'b000) begin
            n_err++;
            $display("FAIL arst_immediate: got %b%b%b expected 000", cnt, valid, vld_o);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b0, 2'b11, "arst_stay_zero");
        cycle(1'b1, 2'b10, "arst_recapture");
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic       e;
            logic [1:0] d;
            e = 1'($urandom_range(1));
            d = 2'($urandom_range(3));
            cycle(e, d, "random");
        end
    endtask

    task automatic test_comb();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] d;
            logic       e;
            d = 2'(i % 4);
            e = 1'(i / 4);
            c_din = d;
            c_en  = e;
            #1;
            n_cmp++;
            if ({c_cnt, c_valid, c_vld} !== {(ref_lz({2'b00, d}, 2) == 1), (d != 2'b00), e}) begin
                n_err++;
                $display("FAIL comb din=%b en=%b: got %b%b%b", d, e, c_cnt, c_valid, c_vld);
            end
        end
    endtask

    task automatic test_tree();
        logic [3:0] pats [4];
        pats[0] = 4'b0011; pats[1] = 4'b0101; pats[2] = 4'b0000; pats[3] = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = (i < 4) ? pats[i] : 4'($urandom_range(15));
            din4 = v;
            #1;
            n_cmp++;
            if (node_s.cnt !== 2'(ref_lz(v, 4)) || node_s.valid !== (v != 4'd0)) begin
                n_err++;
                $display("FAIL tree din4=%b: got cnt=%0d valid=%b expected cnt=%0d valid=%b",
                         v, node_s.cnt, node_s.valid, ref_lz(v, 4), (v != 4'd0));
            end
        end
    endtask

    initial begin
        c_en  = 1'b0;
        c_din = 2'b00;
        din4  = 4'd0;
        test_reset();
        test_sweep();
        test_enable_hold();
        test_async_reset();
        test_random();
        test_comb();
        test_tree();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
